iir_channel_scheduler: RTL and testbench
========================================

Name: iir_channel_scheduler

Overview:
- Time-multiplexes one shared 4-bit signed Baugh-Wooley multiplier across NCH independent first-order IIR channels.
- Each channel computes y[n] = x[n] + a·y[n-1].
- Per-channel coefficient and state registers, a round-robin arbiter over sample requesters, and a FSM that sequences grant → multiply → accumulate/write-back.
- Sits between the sample sources and downstream consumers of filtered samples.

Parameters:
- NCH, 4: number of channels/requesters (2..16).
- MUL_LAT, 1: pipeline register stages after the multiplier (1..3).

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous, active-low reset.
- req_valid, input, NCH: per-channel sample request.
- req_x, input, NCH*4: per-channel sample, two's complement; channel i at bits [4i+3:4i].
- req_ready, output, NCH: one-hot grant; the handshake completes when req_valid[i] & req_ready[i].
- cfg_we, input, 1: coefficient write strobe.
- cfg_ch, input, clog2(NCH): coefficient write channel.
- cfg_a, input, 4: coefficient, two's complement.
- out_valid, output, 1: one-cycle result strobe.
- out_ch, output, clog2(NCH): channel of the result.
- out_y, output, 4: filtered sample, two's complement.
- busy, output, 1: FSM not in IDLE.

Behaviour:
- Reset (rst low, asynchronous):
  - FSM → IDLE.
  - All coef[i] = 0 and all ystate[i] = 0.
  - RR pointer = 0 (ch0 highest priority).
  - req_ready = 0, out_valid = 0, out_ch = 0, out_y = 0, busy = 0.
  - Reset mid-operation aborts the in-flight sample with no output.
- FSM states: IDLE, MUL, DONE.
- IDLE:
  - If any req_valid, assert req_ready combinationally for the first requester at or after the RR pointer, wrapping.
  - At the clock edge: capture x, coef, ystate and channel; set RR pointer = grant+1 mod NCH; go to MUL.
  - With no requests: stay in IDLE; req_ready = 0.
- MUL:
  - Multiplier operands are the captured coef and ystate.
  - Product passes through MUL_LAT registers.
  - Stay MUL_LAT cycles, counted by an internal counter, then go to DONE.
- DONE:
  - Compute sum and register it into out_y/out_ch; write ystate[ch] = sum; go to IDLE.
  - out_valid = 1 for exactly the cycle after DONE.
- Latency: the handshake edge is E0; out_valid is high in the cycle following edge E0+MUL_LAT+1.
- Throughput: one sample per MUL_LAT+2 cycles.
- The next grant may occur while out_valid is high.
- Arithmetic (default): sum = (x + prod[3:0]) mod 16, where prod is the full signed 8-bit product. Overflow wraps silently.
- Config write:
  - cfg_we writes coef[cfg_ch] = cfg_a and clears ystate[cfg_ch] = 0 at the same edge.
  - Accepted in any FSM state.
  - A captured operand is not affected.
  - If a cfg write to channel c coincides with the DONE write-back for c, the clear wins (ystate = 0), but out_y still reports the computed sum.
  - cfg_ch ≥ NCH is ignored.
- Fairness: a continuously requesting channel waits at most NCH-1 grants.
- A request dropped before grant is simply not served; req_x must be stable while req_valid is high.

Optional Feature:
- Macro IIR_SCHED_SAT_EN.
- When defined:
  - sum is computed at 9 bits as sext(x) + prod (full 8-bit product).
  - It is saturated to [-8, +7] before output and write-back.
  - An extra output port sat_flag (1 bit) is high with out_valid when clipping occurred.
- When undefined: wrap arithmetic as above; no sat_flag port.

Decomposition:
- Package iir_sched_pkg:
  - DATA_W = 4, PROD_W = 8.
  - FSM state encoding (IDLE = 2'd0, MUL = 2'd1, DONE = 2'd2).
  - SAT_MAX = 4'sd7, SAT_MIN = -4'sd8.
  - Function for round-robin next-grant.
- One sub-module: baugh_wooley_multiplier, the existing 4×4 signed multiplier, instantiated unchanged as the shared resource.
- The MUL_LAT pipeline, arbiter and FSM live in iir_channel_scheduler.

Test Plan:
- NCH=4, MUL_LAT=1. Single channel ch0, coef=2, four requests x=1:
  - Default: out_y = 1, 3, 7, 0xF (-1).
  - With IIR_SCHED_SAT_EN: out_y = 1, 3, 7, 7, sat_flag = 1 on the 4th.
- Negative coefficient: coef[1] = 0xF (-1), ystate primed to 3 via x=3. Then x=0 → out_y = 0xD (-3), out_ch = 1.
- All four req_valid held high from reset:
  - Grants in order 0, 1, 2, 3, 0.
  - Each out_valid exactly 3 cycles after its handshake edge.
  - busy never drops between grants.
- cfg_we to ch2 (cfg_a = 1) in the same cycle as DONE for ch2:
  - out_y shows the computed sum.
  - The next ch2 sample with x=5 returns 5 (state cleared).
- Assert rst low during MUL:
  - out_valid never asserts; all outputs are 0 immediately.
  - After release, ch0 x=4 → out_y = 4 (coef reset to 0).
- MUL_LAT=3: handshake-to-out_valid spacing is 5 cycles; two back-to-back requests on ch0/ch1 are spaced 5 cycles at the output.

Source files
------------

// File: rtl/iir_channel_scheduler_pkg.sv
// Shared widths, FSM encoding, saturation limits and round-robin pick for the IIR scheduler.
// Combinational helpers only; no latency, no flow control.
package iir_sched_pkg;

  localparam int DATA_W = 4;
  localparam int PROD_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic signed [DATA_W-1:0] SAT_MAX = 4'sd7;
  localparam logic signed [DATA_W-1:0] SAT_MIN = -4'sd8;

  // First requester at or after ptr, wrapping over nch channels (nch <= 16).
  function automatic logic [3:0] rr_pick(input logic [15:0] vld, input logic [3:0] ptr,
                                         input int nch);
    logic [4:0] idx;
    logic       found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 0; k < 16; k++) begin
      idx = {1'b0, ptr} + 5'(k);
      if (idx >= 5'(nch)) idx = idx - 5'(nch);
      if (k < nch && !found && vld[idx[3:0]]) begin
        rr_pick = idx[3:0];
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/iir_channel_scheduler_if.sv
// Request / config / result bundle of the IIR channel scheduler; sat_flag exists only
// with IIR_SCHED_SAT_EN. Sources drive through master, the scheduler sits on slave.
interface iir_channel_scheduler_if import iir_sched_pkg::*; #(parameter int NCH = 4);

  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0]        req_valid;
  logic [NCH*DATA_W-1:0] req_x;
  logic [NCH-1:0]        req_ready;
  logic                  cfg_we;
  logic [CH_W-1:0]       cfg_ch;
  logic [DATA_W-1:0]     cfg_a;
  logic                  out_valid;
  logic [CH_W-1:0]       out_ch;
  logic [DATA_W-1:0]     out_y;
  logic                  busy;
`ifdef IIR_SCHED_SAT_EN
  logic                  sat_flag;
`endif

  modport master (
    output req_valid, req_x, cfg_we, cfg_ch, cfg_a,
    input  req_ready, out_valid, out_ch, out_y, busy
`ifdef IIR_SCHED_SAT_EN
    , input sat_flag
`endif
  );

  modport slave (
    input  req_valid, req_x, cfg_we, cfg_ch, cfg_a,
    output req_ready, out_valid, out_ch, out_y, busy
`ifdef IIR_SCHED_SAT_EN
    , output sat_flag
`endif
  );

endinterface

// File: rtl/baugh_wooley_multiplier.sv
// 4x4 signed Baugh-Wooley multiplier, purely combinational (zero latency).
// No flow control: the product follows the operands.
module baugh_wooley_multiplier (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  logic [7:0] acc;
  logic       pp;

  // Sign-row partial products are inverted; 2^4 + 2^7 restores the two's-complement result.
  always_comb begin
    acc = 8'b1001_0000;
    pp  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        pp = a[i] & b[j];
        if ((i == 3) != (j == 3)) pp = ~pp;
        acc = acc + (8'(pp) << (i + j));
      end
    end
    p = acc;
  end

endmodule

// File: rtl/iir_channel_scheduler.sv
// Round-robin shares one 4x4 multiplier over NCH y = x + a*y[n-1] channels; result MUL_LAT+2 cycles after grant.
// One sample in flight, req_ready only in IDLE; IIR_SCHED_SAT_EN selects saturating sums plus sat_flag.
module iir_channel_scheduler import iir_sched_pkg::*; #(
  parameter int NCH     = 4,
  parameter int MUL_LAT = 1
) (
  input logic                   clk,
  input logic                   rst,
  iir_channel_scheduler_if.slave bus
);

  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [NCH-1:0] ONE = 1;

  state_e            state, state_nxt;
  logic [DATA_W-1:0] coef   [NCH];
  logic [DATA_W-1:0] ystate [NCH];
  logic [CH_W-1:0]   rr_ptr, cur_ch, gnt_ch, ptr_nxt;
  logic [DATA_W-1:0] cur_x, op_a, op_y, sum;
  logic [PROD_W-1:0] prod, prod_last;
  logic [PROD_W-1:0] prod_pipe [MUL_LAT];
  logic [1:0]        cnt;
  logic              any_req, grant_en;

  assign any_req  = |bus.req_valid;
  assign grant_en = (state == IDLE) && any_req;
  assign gnt_ch   = CH_W'(rr_pick(16'(bus.req_valid), 4'(rr_ptr), NCH));
  assign ptr_nxt  = (gnt_ch == CH_W'(NCH - 1)) ? '0 : gnt_ch + CH_W'(1);

  // Gated by rst so no grant is offered while reset is held.
  assign bus.req_ready = (rst && grant_en) ? (ONE << gnt_ch) : '0;
  assign bus.busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = MUL;
      MUL:     if (cnt == 2'(MUL_LAT - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == MUL) ? cnt + 2'd1 : 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
      cur_ch <= '0;
      cur_x  <= '0;
      op_a   <= '0;
      op_y   <= '0;
    end else if (grant_en) begin
      rr_ptr <= ptr_nxt;
      cur_ch <= gnt_ch;
      cur_x  <= bus.req_x[DATA_W*gnt_ch +: DATA_W];
      op_a   <= coef[gnt_ch];
      op_y   <= ystate[gnt_ch];
    end
  end

  baugh_wooley_multiplier u_mul (
    .a (op_a),
    .b (op_y),
    .p (prod)
  );

  // Free-running shift: operands are stable for all of MUL, so the last stage is valid in DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MUL_LAT; i++) prod_pipe[i] <= '0;
    end else begin
      prod_pipe[0] <= prod;
      for (int i = 1; i < MUL_LAT; i++) prod_pipe[i] <= prod_pipe[i-1];
    end
  end

  assign prod_last = prod_pipe[MUL_LAT-1];

`ifdef IIR_SCHED_SAT_EN
  localparam logic signed [PROD_W:0] WIDE_MAX = SAT_MAX;
  localparam logic signed [PROD_W:0] WIDE_MIN = SAT_MIN;
  logic signed [PROD_W:0] wide;
  logic                   clip;

  always_comb begin
    wide = {{(PROD_W+1-DATA_W){cur_x[DATA_W-1]}}, cur_x} + {prod_last[PROD_W-1], prod_last};
    clip = 1'b0;
    sum  = wide[DATA_W-1:0];
    if (wide > WIDE_MAX) begin
      sum  = SAT_MAX;
      clip = 1'b1;
    end else if (wide < WIDE_MIN) begin
      sum  = SAT_MIN;
      clip = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bus.sat_flag <= 1'b0;
    else      bus.sat_flag <= (state == DONE) && clip;
  end
`else
  assign sum = DATA_W'({{(PROD_W-DATA_W){1'b0}}, cur_x} + prod_last);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.out_valid <= 1'b0;
      bus.out_ch    <= '0;
      bus.out_y     <= '0;
    end else begin
      bus.out_valid <= (state == DONE);
      if (state == DONE) begin
        bus.out_ch <= cur_ch;
        bus.out_y  <= sum;
      end
    end
  end

  // A config write to the channel being written back wins: its state is cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NCH; i++) begin
        coef[i]   <= '0;
        ystate[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (state == DONE && cur_ch == CH_W'(i)) ystate[i] <= sum;
        if (bus.cfg_we && bus.cfg_ch == CH_W'(i)) begin
          coef[i]   <= bus.cfg_a;
          ystate[i] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_iir_channel_scheduler.sv
// Bench for iir_channel_scheduler: instance 0 has MUL_LAT=1, instance 1 has MUL_LAT=3, NCH=4,
// each paired with a transaction-level reference model.
module tb_iir_channel_scheduler;

  localparam int NCH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  iir_channel_scheduler_if #(.NCH(NCH)) if1 ();
  iir_channel_scheduler_if #(.NCH(NCH)) if3 ();

  iir_channel_scheduler #(.NCH(NCH), .MUL_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  iir_channel_scheduler #(.NCH(NCH), .MUL_LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

  logic [3:0]  rv  [2];
  logic [15:0] rx  [2];
  logic        cwe [2];
  logic [1:0]  cch [2];
  logic [3:0]  ca  [2];
  logic [3:0]  rdy [2];
  logic        ov  [2];
  logic [1:0]  och [2];
  logic [3:0]  oy  [2];
  logic        bsy [2];

  assign if1.req_valid = rv[0];  assign if3.req_valid = rv[1];
  assign if1.req_x     = rx[0];  assign if3.req_x     = rx[1];
  assign if1.cfg_we    = cwe[0]; assign if3.cfg_we    = cwe[1];
  assign if1.cfg_ch    = cch[0]; assign if3.cfg_ch    = cch[1];
  assign if1.cfg_a     = ca[0];  assign if3.cfg_a     = ca[1];
  assign rdy[0] = if1.req_ready; assign rdy[1] = if3.req_ready;
  assign ov[0]  = if1.out_valid; assign ov[1]  = if3.out_valid;
  assign och[0] = if1.out_ch;    assign och[1] = if3.out_ch;
  assign oy[0]  = if1.out_y;     assign oy[1]  = if3.out_y;
  assign bsy[0] = if1.busy;      assign bsy[1] = if3.busy;
`ifdef IIR_SCHED_SAT_EN
  logic sat [2];
  assign sat[0] = if1.sat_flag;  assign sat[1] = if3.sat_flag;
`endif

  int n_chk = 0, n_pass = 0, n_fail = 0, cycle = 0;
  int lat [2] = '{1, 3};

  // Reference model: per-channel coefficient/state, RR pointer, edges left on the in-flight sample.
  int m_coef [2][4];
  int m_ys   [2][4];
  int m_ptr [2], m_cnt [2], m_pch [2], m_py [2], m_psat [2];
  int m_och [2], m_oy [2], m_osat [2];
  bit m_ov  [2];

  int obs_y [2][$];
  int obs_ch [2][$];
  int obs_sat [2][$];
  int mod_y [2][$];
  int hs_ch [2][$];
  int hs_cyc [2][$];
  int out_cyc [2][$];
  bit [3:0] hs_flag [2];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cycle, act, exp);
    end
  endtask

  function automatic int s4(input int v);
    int u;
    u = v & 15;
    return (u >= 8) ? u - 16 : u;
  endfunction

  always @(negedge clk) begin
    int g, er, full;
    bit nov;
    cycle++;
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        for (int c = 0; c < 4; c++) begin m_coef[k][c] = 0; m_ys[k][c] = 0; end
        m_ptr[k] = 0; m_cnt[k] = 0; m_ov[k] = 0; hs_flag[k] = '0;
        chk("rst_req_ready", int'(rdy[k]), 0);
        chk("rst_out_valid", int'(ov[k]), 0);
        chk("rst_out_ch", int'(och[k]), 0);
        chk("rst_out_y", int'(oy[k]), 0);
        chk("rst_busy", int'(bsy[k]), 0);
      end else begin
        g = -1;
        if (m_cnt[k] == 0)
          for (int j = 3; j >= 0; j--)
            if (rv[k][(m_ptr[k] + j) % 4]) g = (m_ptr[k] + j) % 4;
        er = (g >= 0) ? (1 << g) : 0;
        chk("req_ready", int'(rdy[k]), er);
        chk("busy", int'(bsy[k]), int'(m_cnt[k] != 0));
        chk("out_valid", int'(ov[k]), int'(m_ov[k]));
        if (m_ov[k]) begin
          chk("out_ch", int'(och[k]), m_och[k]);
          chk("out_y", int'(oy[k]), m_oy[k]);
`ifdef IIR_SCHED_SAT_EN
          chk("sat_flag", int'(sat[k]), m_osat[k]);
`endif
          mod_y[k].push_back(m_oy[k]);
        end
        if (ov[k]) begin
          obs_y[k].push_back(int'(oy[k]));
          obs_ch[k].push_back(int'(och[k]));
`ifdef IIR_SCHED_SAT_EN
          obs_sat[k].push_back(int'(sat[k]));
`else
          obs_sat[k].push_back(0);
`endif
          out_cyc[k].push_back(cycle);
        end
        for (int c = 0; c < 4; c++)
          if (rv[k][c] && rdy[k][c]) begin
            hs_ch[k].push_back(c);
            hs_cyc[k].push_back(cycle);
            hs_flag[k][c] = 1'b1;
          end
        // Advance to the coming edge: write-back first, a config write at the same edge overrides it.
        nov = 0;
        if (m_cnt[k] > 0) begin
          m_cnt[k]--;
          if (m_cnt[k] == 0) begin
            m_ys[k][m_pch[k]] = m_py[k];
            nov = 1;
            m_och[k] = m_pch[k]; m_oy[k] = m_py[k]; m_osat[k] = m_psat[k];
          end
        end else if (g >= 0) begin
          full = s4(int'(rx[k][4*g +: 4])) + s4(m_coef[k][g]) * s4(m_ys[k][g]);
`ifdef IIR_SCHED_SAT_EN
          m_psat[k] = (full > 7 || full < -8) ? 1 : 0;
          full = (full > 7) ? 7 : (full < -8) ? -8 : full;
`else
          m_psat[k] = 0;
`endif
          m_py[k]  = full & 15;
          m_pch[k] = g;
          m_ptr[k] = (g + 1) % 4;
          m_cnt[k] = lat[k] + 1;
        end
        if (cwe[k]) begin
          m_coef[k][cch[k]] = int'(ca[k]);
          m_ys[k][cch[k]]   = 0;
        end
        m_ov[k] = nov;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic cfg(input int k, input int ch, input int a);
    cwe[k] = 1'b1; cch[k] = 2'(ch); ca[k] = 4'(a);
    cyc(1);
    cwe[k] = 1'b0;
  endtask

  // Raise a request, hold it until granted, drop it; optionally fire a config write at the DONE edge.
  task automatic serve(input int k, input int ch, input int x, input bit cfg_at_done, input int ca_v);
    int t;
    hs_flag[k][ch] = 1'b0;
    rv[k][ch] = 1'b1;
    rx[k][4*ch +: 4] = 4'(x);
    t = 0;
    do begin @(posedge clk); #1; t++; end while (!hs_flag[k][ch] && t < 40);
    chk("serve_grant", int'(hs_flag[k][ch]), 1);
    hs_flag[k][ch] = 1'b0;
    rv[k][ch] = 1'b0;
    if (cfg_at_done) begin
      cyc(lat[k]);
      cfg(k, ch, ca_v);
    end else cyc(lat[k] + 1);
  endtask

  task automatic clear_logs();
    for (int k = 0; k < 2; k++) begin
      obs_y[k].delete(); obs_ch[k].delete(); obs_sat[k].delete(); mod_y[k].delete();
      hs_ch[k].delete(); hs_cyc[k].delete(); out_cyc[k].delete();
    end
  endtask

  initial begin
    int t1e [4];
    int t1s [4];
    int t3e [5];
    int nobs;
`ifdef IIR_SCHED_SAT_EN
    t1e = '{1, 3, 7, 7};  t1s = '{0, 0, 0, 1};
`else
    t1e = '{1, 3, 7, 15}; t1s = '{0, 0, 0, 0};
`endif
    t3e = '{0, 1, 2, 3, 0};
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rv[k] = '0; rx[k] = '0; cwe[k] = 1'b0; cch[k] = '0; ca[k] = '0;
    end
    cyc(3);
    rst = 1'b1;
    cyc(1);

    // Coefficient 2 on ch0, four x=1 samples.
    cfg(0, 0, 2);
    clear_logs();
    repeat (4) serve(0, 0, 1, 1'b0, 0);
    cyc(2);
    chk("t1_count", obs_y[0].size(), 4);
    for (int i = 0; i < 4 && i < obs_y[0].size(); i++) begin
      chk("t1_out_y", obs_y[0][i], t1e[i]);
      chk("t1_sat", obs_sat[0][i], t1s[i]);
      chk("t1_model_y", mod_y[0][i], t1e[i]);
    end

    // Coefficient -1 on ch1, state primed to 3, then x=0 gives -3.
    cfg(0, 1, 15);
    clear_logs();
    serve(0, 1, 3, 1'b0, 0);
    serve(0, 1, 0, 1'b0, 0);
    cyc(2);
    chk("t2_count", obs_y[0].size(), 2);
    if (obs_y[0].size() == 2) begin
      chk("t2_out_y", obs_y[0][1], 13);
      chk("t2_out_ch", obs_ch[0][1], 1);
    end

    // All four requesters held from reset.
    rst = 1'b0;
    rv[0] = 4'hF; rx[0] = 16'h1111;
    cyc(2);
    clear_logs();
    rst = 1'b1;
    cyc(18);
    rv[0] = 4'h0;
    cyc(6);
    chk("t3_grants", int'(hs_ch[0].size() >= 5), 1);
    for (int i = 0; i < 5 && i < hs_ch[0].size(); i++) chk("t3_order", hs_ch[0][i], t3e[i]);
    for (int i = 0; i < 4 && i < out_cyc[0].size() && i < hs_cyc[0].size(); i++)
      chk("t3_latency", out_cyc[0][i] - hs_cyc[0][i], 3);

    // Config write to ch2 coinciding with its write-back.
    cfg(0, 2, 3);
    clear_logs();
    serve(0, 2, 2, 1'b0, 0);
    serve(0, 2, 1, 1'b1, 1);
    serve(0, 2, 5, 1'b0, 0);
    cyc(2);
    chk("t4_count", obs_y[0].size(), 3);
    if (obs_y[0].size() == 3) begin
      chk("t4_first", obs_y[0][0], 2);
      chk("t4_collide_sum", obs_y[0][1], 7);
      chk("t4_after_clear", obs_y[0][2], 5);
      chk("t4_out_ch", obs_ch[0][2], 2);
    end

    // Reset during MUL aborts the sample.
    cfg(0, 0, 3);
    serve(0, 0, 1, 1'b0, 0);
    cyc(1);
    hs_flag[0] = '0;
    rv[0][0] = 1'b1; rx[0][3:0] = 4'd2;
    begin
      int t;
      t = 0;
      do begin @(posedge clk); #1; t++; end while (!hs_flag[0][0] && t < 40);
      chk("t5_grant", int'(hs_flag[0][0]), 1);
    end
    rv[0][0] = 1'b0;
    rst = 1'b0;
    #1;
    chk("t5_out_y_now", int'(oy[0]), 0);
    chk("t5_out_ch_now", int'(och[0]), 0);
    chk("t5_out_valid_now", int'(ov[0]), 0);
    chk("t5_busy_now", int'(bsy[0]), 0);
    chk("t5_ready_now", int'(rdy[0]), 0);
    nobs = obs_y[0].size();
    cyc(3);
    rst = 1'b1;
    cyc(3);
    chk("t5_no_output", obs_y[0].size(), nobs);
    serve(0, 0, 4, 1'b0, 0);
    cyc(2);
    chk("t5_count", obs_y[0].size(), nobs + 1);
    if (obs_y[0].size() == nobs + 1) chk("t5_out_y", obs_y[0][nobs], 4);

    // MUL_LAT=3: back-to-back requests on ch0 and ch1.
    clear_logs();
    hs_flag[1] = '0;
    rv[1] = 4'b0011; rx[1] = 16'h0021;
    repeat (20) begin
      cyc(1);
      rv[1] = rv[1] & ~hs_flag[1];
      hs_flag[1] = '0;
    end
    chk("t6_hs_count", hs_ch[1].size(), 2);
    chk("t6_out_count", out_cyc[1].size(), 2);
    if (hs_ch[1].size() == 2 && out_cyc[1].size() == 2) begin
      chk("t6_first_ch", hs_ch[1][0], 0);
      chk("t6_second_ch", hs_ch[1][1], 1);
      chk("t6_latency0", out_cyc[1][0] - hs_cyc[1][0], 5);
      chk("t6_latency1", out_cyc[1][1] - hs_cyc[1][1], 5);
      chk("t6_out_spacing", out_cyc[1][1] - out_cyc[1][0], 5);
      chk("t6_y0", obs_y[1][0], 1);
      chk("t6_y1", obs_y[1][1], 2);
    end

    // Randomised traffic and config writes on both instances.
    hs_flag[0] = '0; hs_flag[1] = '0;
    repeat (3000) begin
      cyc(1);
      for (int k = 0; k < 2; k++) begin
        for (int c = 0; c < 4; c++) begin
          if (hs_flag[k][c]) begin
            hs_flag[k][c] = 1'b0;
            rv[k][c] = ($urandom_range(1, 0) == 1);
            if (rv[k][c]) rx[k][4*c +: 4] = 4'($urandom);
          end else if (!rv[k][c]) begin
            if ($urandom_range(99, 0) < 30) begin
              rv[k][c] = 1'b1;
              rx[k][4*c +: 4] = 4'($urandom);
            end
          end else if ($urandom_range(99, 0) < 3) rv[k][c] = 1'b0;
        end
        cwe[k] = ($urandom_range(99, 0) < 8);
        cch[k] = 2'($urandom);
        ca[k]  = 4'($urandom);
      end
    end
    for (int k = 0; k < 2; k++) begin rv[k] = '0; cwe[k] = 1'b0; end
    cyc(8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
